// File: rtl/lcd_fetch_pkg.sv
// lcd_pkg: shared constants, FSM states and font address selection for the LCD fetch path.
package lcd_pkg;
  localparam int NCOLS = 106;
  localparam int NROWS = 8;
  localparam int NLINES = 8;
  localparam int COL_W = 7;
  localparam int VA_W = 22;
  localparam int HI_HIRES = 7;
  localparam int HI_REV = 6;
  localparam int HI_FLASH = 5;
  localparam int HI_GREY = 4;
  localparam int HI_UL = 3;
  localparam int HIRES0_LIMIT = 768;
  localparam logic [2:0] LORES0_CODE = 3'b111;
  typedef enum logic [1:0] {IDLE, ALO, AHI, FONT} state_t;
  function automatic logic [VA_W-1:0] font_addr(input logic hires, input logic [9:0] code,
      input logic [2:0] line, input logic [12:0] pb0, input logic [9:0] pb1,
      input logic [8:0] pb2, input logic [10:0] pb3);
    if (hires) return (int'(code) < HIRES0_LIMIT) ? {pb2, code, line} : {pb3, code[7:0], line};
    return (code[8:6] == LORES0_CODE) ? {pb0, code[5:0], line} : {pb1, code[8:0], line};
  endfunction
endpackage

// File: rtl/lcd_fetch_if.sv
// lcd_fetch_if: memory-side fetch bus and pixel FIFO read port of the LCD fetch block.
interface lcd_fetch_if;
  import lcd_pkg::*;
  logic [1:0] clkcnt;
  logic lcdon;
  logic [12:0] pb0;
  logic [9:0] pb1;
  logic [8:0] pb2;
  logic [10:0] pb3;
  logic [10:0] sbr;
  logic [VA_W-1:0] va;
  logic [7:0] vdi;
  logic [7:0] pix_data;
  logic [5:0] pix_attr;
  logic pix_valid;
  logic pix_rd;
  logic frame_done;
  modport master(input clkcnt, lcdon, pb0, pb1, pb2, pb3, sbr, vdi, pix_rd,
                 output va, pix_data, pix_attr, pix_valid, frame_done);
  modport slave(output clkcnt, lcdon, pb0, pb1, pb2, pb3, sbr, vdi, pix_rd,
                input va, pix_data, pix_attr, pix_valid, frame_done);
endinterface

// File: rtl/vid_fifo.sv
// vid_fifo: count-based synchronous FIFO with first-word fall-through head and flush.
module vid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    valid_o = cnt_q != '0;
    full_o = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop_i & valid_o;
    do_push = push_i & (!full_o | do_pop);
    dout_o = valid_o ? mem_q[rd_q] : '0;
  end
  always_ff @(posedge clk)
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or posedge rst)
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/lcd_fetch.sv
// lcd_fetch: walks screen and font bases in raster order on video slots, queueing pixel bytes.
module lcd_fetch #(
  parameter int NCOLS = lcd_pkg::NCOLS,
  parameter int FIFO_DEPTH = 4
) (
  input logic mck,
  input logic res,
  lcd_fetch_if.master bus
);
  import lcd_pkg::*;
  state_t state_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0] line_q, line_d, row_q, row_d;
  logic [7:0] lo_q;
  logic [3:0] attr_q;
  logic [VA_W-1:0] va_q;
  logic fd_q, video, last_col, last, full, push, sol, sof;
  logic [13:0] fifo_dout;
  always_comb begin
    video = bus.clkcnt != 2'd2;
    last_col = col_q == COL_W'(NCOLS - 1);
    last = last_col & (&line_q) & (&row_q);
    col_d = last_col ? '0 : col_q + 1'b1;
    line_d = line_q + 3'(last_col);
    row_d = row_q + 3'(last_col & (&line_q));
    sol = col_q == '0;
    sof = sol & (line_q == '0) & (row_q == '0);
    push = bus.lcdon & video & (state_q == FONT) & (!full | bus.pix_rd);
  end
  always_ff @(posedge mck or posedge res)
    if (res) begin
      state_q <= IDLE;
      va_q <= '0;
      col_q <= '0;
      line_q <= '0;
      row_q <= '0;
      lo_q <= '0;
      attr_q <= '0;
      fd_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (!bus.lcdon) begin
        state_q <= IDLE;
        va_q <= '0;
        col_q <= '0;
        line_q <= '0;
        row_q <= '0;
      end else if (video)
        case (state_q)
          IDLE: begin
            state_q <= ALO;
            va_q <= {bus.sbr, row_q, col_q, 1'b0};
          end
          ALO: begin
            lo_q <= bus.vdi;
            state_q <= AHI;
            va_q <= {bus.sbr, row_q, col_q, 1'b1};
          end
          AHI: begin
            attr_q <= bus.vdi[HI_REV:HI_UL];
            state_q <= FONT;
            va_q <= font_addr(bus.vdi[HI_HIRES], {bus.vdi[1:0], lo_q}, line_q,
                              bus.pb0, bus.pb1, bus.pb2, bus.pb3);
          end
          FONT:
            // a full FIFO with no pop parks here, keeping the font address on the bus
            if (push) begin
              col_q <= col_d;
              line_q <= line_d;
              row_q <= row_d;
              fd_q <= last;
              state_q <= ALO;
              va_q <= {bus.sbr, row_d, col_d, 1'b0};
            end
        endcase
    end
  vid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(14)) u_fifo (
    .clk(mck),
    .rst(res),
    .flush_i(!bus.lcdon),
    .push_i(push),
    .pop_i(bus.pix_rd),
    .din_i({bus.vdi, sof, sol, attr_q}),
    .dout_o(fifo_dout),
    .valid_o(bus.pix_valid),
    .full_o(full)
  );
  assign bus.va = va_q;
  assign bus.frame_done = fd_q;
  assign bus.pix_data = fifo_dout[13:6];
  assign bus.pix_attr = fifo_dout[5:0];
endmodule

// File: doc/lcd_fetch.md
# lcd_fetch

Video fetch scheduler for the LCD path. It walks the screen base file (SBR) and the four font/graphics bases (PB0–PB3) in raster order, driving the video address bus `va` during video slots only. Z80 slots are those where `clkcnt == 2`. Each character cell yields one pixel byte plus attribute flags, which are pushed into a small FIFO drained by the LCD shifter. It sits between the memory controller (blink's `va`/`vid_cdo`) and the LCD serialiser.

## Interface
Parameters:
- `NCOLS`, 106, characters per text row
- `FIFO_DEPTH`, 4, pixel FIFO entries (power of two)

Ports:
- `mck`  in  1  9.83 MHz master clock
- `res`  in  1  reset, asynchronous, active-high
- `clkcnt`  in  2  Z80 slot phase; video slot when `!= 2`
- `lcdon`  in  1  display enable (COM bit 0)
- `pb0`  in  13  lores0 base
- `pb1`  in  10  lores1 base
- `pb2`  in  9  hires0 base
- `pb3`  in  11  hires1 base
- `sbr`  in  11  screen base file
- `va`  out  22  video memory address
- `vdi`  in  8  video read data, valid at end of slot cycle
- `pix_data`  out  8  FIFO head pixel byte
- `pix_attr`  out  6  FIFO head `{sof, sol, reverse, flash, grey, underline}`
- `pix_valid`  out  1  FIFO non-empty
- `pix_rd`  in  1  pop FIFO head; ignored when empty
- `frame_done`  out  1  one-cycle pulse after last cell of frame

## Operation
- Counters:
  - `col` 0..NCOLS-1
  - `line` 0..7 (pixel line within row)
  - `row` 0..7
- Raster order: col fastest, then line, then row.
- Attribute high byte `hi`:
  - [7] hires
  - [6] reverse
  - [5] flash
  - [4] grey
  - [3] underline
  - [2] unused
  - [1:0] code high bits
- FSM states: IDLE, ALO, AHI, FONT. State advances only on a video slot; it holds otherwise, with `va` stable.
  - IDLE: `va = 0`. Go to ALO when `lcdon = 1`, with all counters at 0.
  - ALO: `va = {sbr, row, col, 1'b0}`; latch `vdi` → `lo`.
  - AHI: `va = {sbr, row, col, 1'b1}`; latch `vdi` → `hi`.
  - FONT: `va` selected by character type:
    - hires, `{hi[1:0],lo} < 768` → `{pb2, hi[1:0], lo, line}`
    - hires, otherwise → `{pb3, lo, line}`
    - lores, `{hi[0],lo}[8:6] == 3'b111` → `{pb0, lo[5:0], line}`
    - lores, otherwise → `{pb1, hi[0], lo, line}`
  - FONT push: `{vdi, sof, sol, hi[6:3]}` into the FIFO.
    - `sol = (col == 0)`
    - `sof = sol & line == 0 & row == 0`
    - If the FIFO is full and `pix_rd = 0`, stay in FONT and re-issue on the next slot.
    - On push, advance the counters and return to ALO.
    - After the last cell (col NCOLS-1, line 7, row 7): pulse `frame_done`, reset counters, go to ALO if `lcdon` else IDLE.
- `lcdon` low in any state: go to IDLE next `mck` edge, flush the FIFO, clear counters. No push occurs in that cycle.
- FIFO rules:
  - Simultaneous push and pop when full or non-empty: both occur, count unchanged.
  - Pop when empty: ignored.
- Reset values: IDLE, `va = 0`, counters 0, FIFO empty, `pix_valid = 0`, `pix_data = 0`, `pix_attr = 0`, `frame_done = 0`.

## Timing
- `va` is registered and updated on the `mck` edge that ends a video slot.
  - Presented for the whole next slot.
  - During a Z80 slot `va` holds; blink muxes it out.
- `vdi` is sampled on the edge ending the slot in which `va` was driven; there are no wait states.
- Cost per cell: 3 video slots. Steady-state throughput: 1 cell per 4.5 `mck` on average.
- Push to `pix_valid`: 1 cycle.
- FIFO output is registered head (first-word fall-through); `pix_rd` pops on the same edge.
- Full frame: 8 × 8 × NCOLS = 6784 cells.

## Structure
- Shared package `lcd_pkg`:
  - `NCOLS`
  - Rows/lines constants (8)
  - Hi-byte bit indices
  - FSM state enum
  - `HIRES0_LIMIT = 768`
  - `LORES0_CODE = 3'b111`
- Sub-module: `vid_fifo` (parameterised depth/width, synchronous, count-based full/empty).

## Test plan
- Reset asserted mid-fetch → next edge: `va = 0`, `pix_valid = 0`, state IDLE; held until release.
- Lores1 cell:
  - Setup: `sbr = 11'h7F0`, `pb1 = 10'h3C0`, `lcdon` ↑.
  - Expect `va` sequence `22'h3F8000`, `22'h3F8001`.
  - Return `lo = 8'h41`, `hi = 8'h00` → font `va = 22'h3C0208`.
  - Push `pix_attr = 6'b110000` (sof, sol).
- Hires/lores0 select:
  - `hi = 8'h83`, `lo = 8'h00` → `{pb3, 8'h00, line}`.
  - `hi = 8'h01`, `lo = 8'hC5` → `{pb0, 6'h05, line}`.
- Back-pressure:
  - `pix_rd = 0` → exactly 4 pushes, then FSM parks in FONT with `va` stable.
  - One `pix_rd` → exactly one more push.
- Wrap:
  - 106th cell → `col = 0`, line 1 (font `va` low bits `3'b001`).
  - After 6784 pushes → single `frame_done` pulse; next ALO `va = {sbr, 11'h000}`.
- `lcdon` dropped during AHI → IDLE next cycle, `pix_valid = 0`; re-enable restarts at row 0, col 0.
